// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared 5x7 LED matrix constants, types and helpers
package matrix_pkg;

    localparam int MATRIX_COLUMNS = 5;
    localparam int MATRIX_ROWS    = 7;
    localparam logic [MATRIX_ROWS-1:0] PIXEL_ROW_OFF = 7'h7F;

    typedef logic [2:0]                col_index_t;
    typedef logic [MATRIX_ROWS-1:0]    row_pattern_t;
    typedef logic [MATRIX_COLUMNS-1:0] col_onehot_t;

    function automatic col_onehot_t index_to_onehot(input col_index_t idx);
        col_onehot_t onehot;
        onehot = '0;
        for (int i = 0; i < MATRIX_COLUMNS; i++) begin
            if (idx == col_index_t'(i)) begin
                onehot[i] = 1'b1;
            end
        end
        return onehot;
    endfunction

    function automatic col_index_t next_index(input col_index_t idx);
        return (idx == col_index_t'(MATRIX_COLUMNS - 1)) ? '0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/matrix_scan_timer.sv
// rtl/matrix_scan_timer.sv - slot prescaler, column index and blink phase timing
module matrix_scan_timer
    import matrix_pkg::*;
#(
    parameter int DWELL        = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int BLINK_FRAMES = 100
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    output logic       slot_start,
    output logic       frame_wrap,
    output logic       active_window,
    output col_index_t index,
    output logic       blink_phase
);

    localparam int PW = $clog2(DWELL);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0] prescaler;
    logic [FW-1:0] frame_count;
    logic          slot_wrap;

    assign slot_wrap     = (prescaler == PW'(DWELL - 1));
    assign frame_wrap    = slot_wrap && (index == col_index_t'(MATRIX_COLUMNS - 1));
    assign slot_start    = (prescaler == '0);
    assign active_window = (prescaler >= PW'(BLANK_CYCLES));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prescaler   <= '0;
            index       <= '0;
            frame_count <= '0;
            blink_phase <= 1'b0;
        end else if (!enable) begin
            // Disabling restarts the whole scan so re-enable begins at column 0.
            prescaler   <= '0;
            index       <= '0;
            frame_count <= '0;
            blink_phase <= 1'b0;
        end else begin
            prescaler <= slot_wrap ? '0 : prescaler + 1'b1;
            if (slot_wrap) begin
                index <= next_index(index);
            end
            if (frame_wrap) begin
                if (frame_count == FW'(BLINK_FRAMES - 1)) begin
                    frame_count <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_count <= frame_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/matrix_column_scanner.sv
// rtl/matrix_column_scanner.sv - tear-free, blanked column multiplexer for a 5x7 LED matrix
module matrix_column_scanner
    import matrix_pkg::*;
#(
    parameter int CLOCK_HZ     = 50000000,
    parameter int COLUMN_HZ    = 1000,
    parameter int BLANK_CYCLES = 500,
    parameter int BLINK_FRAMES = 100
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       blink,
    input  logic [6:0] column_4,
    input  logic [6:0] column_3,
    input  logic [6:0] column_2,
    input  logic [6:0] column_1,
    input  logic [6:0] column_0,
    output logic [6:0] rows,
    output logic [4:0] column_select,
    output logic       frame_start
);

    localparam int DWELL = CLOCK_HZ / COLUMN_HZ;

    logic         slot_start;
    logic         frame_wrap;
    logic         active_window;
    col_index_t   index;
    logic         blink_phase;
    logic         snapshot;
    row_pattern_t shadow [MATRIX_COLUMNS];
    row_pattern_t shadow_row;
    row_pattern_t rows_d;
    col_onehot_t  select_d;

    matrix_scan_timer #(
        .DWELL        (DWELL),
        .BLANK_CYCLES (BLANK_CYCLES),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_timer (
        .clock         (clock),
        .reset_n       (reset_n),
        .enable        (enable),
        .slot_start    (slot_start),
        .frame_wrap    (frame_wrap),
        .active_window (active_window),
        .index         (index),
        .blink_phase   (blink_phase)
    );

    // The image is latched only at the very start of column 0 so a frame never tears.
    assign snapshot = enable && slot_start && (index == '0);

    always_comb begin
        shadow_row = PIXEL_ROW_OFF;
        case (index)
            3'd0:    shadow_row = shadow[0];
            3'd1:    shadow_row = shadow[1];
            3'd2:    shadow_row = shadow[2];
            3'd3:    shadow_row = shadow[3];
            3'd4:    shadow_row = shadow[4];
            default: shadow_row = PIXEL_ROW_OFF;
        endcase
    end

    always_comb begin
        rows_d   = PIXEL_ROW_OFF;
        select_d = '0;
        if (enable && active_window) begin
            select_d = index_to_onehot(index);
            rows_d   = (blink && blink_phase) ? PIXEL_ROW_OFF : shadow_row;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rows          <= PIXEL_ROW_OFF;
            column_select <= '0;
            frame_start   <= 1'b0;
            for (int i = 0; i < MATRIX_COLUMNS; i++) begin
                shadow[i] <= PIXEL_ROW_OFF;
            end
        end else begin
            rows          <= rows_d;
            column_select <= select_d;
            frame_start   <= snapshot;
            if (snapshot) begin
                shadow[0] <= column_0;
                shadow[1] <= column_1;
                shadow[2] <= column_2;
                shadow[3] <= column_3;
                shadow[4] <= column_4;
            end
        end
    end

endmodule

// File: tb/tb_matrix_column_scanner.sv
// tb/tb_matrix_column_scanner.sv - self-checking bench for matrix_column_scanner
module tb_matrix_column_scanner;

    localparam int SLOT  = 10;
    localparam int BLANK = 2;
    localparam int FRAME = 5 * SLOT;
    localparam int BLINKF = 2;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       blink;
    logic [6:0] col [5];
    logic [6:0] rows;
    logic [4:0] column_select;
    logic       frame_start;

    int         checks = 0;
    int         errors = 0;
    int         cyc;
    logic [6:0] snap [5];

    matrix_column_scanner #(
        .CLOCK_HZ     (100),
        .COLUMN_HZ    (10),
        .BLANK_CYCLES (BLANK),
        .BLINK_FRAMES (BLINKF)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .enable        (enable),
        .blink         (blink),
        .column_4      (col[4]),
        .column_3      (col[3]),
        .column_2      (col[2]),
        .column_1      (col[1]),
        .column_0      (col[0]),
        .rows          (rows),
        .column_select (column_select),
        .frame_start   (frame_start)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        cyc = 0;
        for (int i = 0; i < 5; i++) snap[i] = 7'h7F;
    endtask

    // Reference: cyc counts edges since the scan (re)started; everything follows from it.
    task automatic tick();
        logic [6:0] er;
        logic [4:0] es;
        logic       ef;
        int         idx;
        er = 7'h7F;
        es = '0;
        ef = 1'b0;
        if (!reset_n) begin
            model_reset();
        end else if (!enable) begin
            cyc = 0;
        end else begin
            if (cyc % FRAME == 0) begin
                for (int i = 0; i < 5; i++) snap[i] = col[i];
                ef = 1'b1;
            end
            idx = (cyc / SLOT) % 5;
            if (cyc % SLOT >= BLANK) begin
                es = 5'(1 << idx);
                er = (blink && ((cyc / (FRAME * BLINKF)) % 2 == 1)) ? 7'h7F : snap[idx];
            end
            cyc++;
        end
        @(posedge clock);
        #1;
        chk("rows", rows, er);
        chk("column_select", {2'b00, column_select}, {2'b00, es});
        chk("frame_start", {6'd0, frame_start}, {6'd0, ef});
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b1;
        blink   = 1'b0;
        col[0] = 7'h01; col[1] = 7'h02; col[2] = 7'h04; col[3] = 7'h08; col[4] = 7'h10;
        model_reset();

        // Reset held, then scan order with the walking-bit image
        run(5);
        reset_n = 1'b1;
        run(2 * FRAME);

        // Tear-free snapshot: change inputs while column 2 is lit
        for (int k = 0; k < FRAME && (cyc % FRAME) != 25; k++) tick();
        for (int i = 0; i < 5; i++) col[i] = 7'($urandom);
        run(2 * FRAME);

        // Blink from a clean restart with every pixel on
        enable = 1'b0;
        tick();
        enable = 1'b1;
        blink  = 1'b1;
        for (int i = 0; i < 5; i++) col[i] = 7'h00;
        run(5 * FRAME);
        blink = 1'b0;

        // Enable dropped mid-slot of column 3, then re-enabled
        for (int i = 0; i < 5; i++) col[i] = 7'($urandom);
        for (int k = 0; k < FRAME && (cyc % FRAME) != 35; k++) tick();
        enable = 1'b0;
        run(3);
        enable = 1'b1;
        run(FRAME + 5);

        // Async reset between edges in the active window
        for (int k = 0; k < FRAME && (cyc % SLOT) != 5; k++) tick();
        for (int i = 0; i < 5; i++) col[i] = 7'h7F;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rows", rows, 7'h7F);
        chk("async_select", {2'b00, column_select}, 7'h00);
        chk("async_frame_start", {6'd0, frame_start}, 7'h00);
        run(2);
        reset_n = 1'b1;
        run(FRAME + 5);

        // Randomised traffic: image changes, blink toggles, brief enable drops
        for (int k = 0; k < 1200; k++) begin
            if ($urandom_range(0, 19) == 0) col[$urandom_range(0, 4)] = 7'($urandom);
            if ($urandom_range(0, 149) == 0) blink = ~blink;
            enable = ($urandom_range(0, 199) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
